// File: rtl/seg7_update_scheduler_if.sv
// Handshake/control bundle for seg7_update_scheduler.
//   req[1:0]             : per-requester display-update requests (bit 0 = requester 0)
//   val0, val1           : 4-digit values of requesters 0 and 1
//   ack[1:0]             : one-cycle completion pulse per requester
//   bus_req / bus_gnt    : bus ownership request / grant from the processor
//   bus_interrupt_raise  : sticky "display updated" flag to the processor
//   bus_interrupt_ack    : processor clears bus_interrupt_raise
// The scheduler uses the master modport; the requester/processor side uses slave.
interface seg7_update_scheduler_if;
    logic [1:0]  req;
    logic [15:0] val0;
    logic [15:0] val1;
    logic [1:0]  ack;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_interrupt_raise;
    logic        bus_interrupt_ack;

    modport master (
        input  req, val0, val1, bus_gnt, bus_interrupt_ack,
        output ack, bus_req, bus_interrupt_raise
    );

    modport slave (
        output req, val0, val1, bus_gnt, bus_interrupt_ack,
        input  ack, bus_req, bus_interrupt_raise
    );
endinterface

// File: rtl/seg7_update_scheduler.sv
// Seven-segment display update scheduler.
// Arbitrates two requesters round-robin, latches the winner's 16-bit value,
// acquires the shared processor bus and writes the low byte to BASE_ADDR and
// the high byte to BASE_ADDR+1, then pulses the winner's ack and raises a
// sticky interrupt.
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset
//   bus_addr : shared address bus (driven only while writing, else Z)
//   bus_data : shared data bus    (driven only while writing, else Z)
//   bus_we   : shared write enable (1 while writing, else Z)
//   ctl      : handshake bundle (see seg7_update_scheduler_if)
module seg7_update_scheduler #(
    parameter logic [7:0] BASE_ADDR = 8'hD0
) (
    input  logic                          clk,
    input  logic                          reset,
    inout  wire  [7:0]                    bus_addr,
    inout  wire  [7:0]                    bus_data,
    inout  wire                           bus_we,
    seg7_update_scheduler_if.master       ctl
);
    // High-byte address wraps modulo 256.
    localparam logic [7:0] HI_ADDR = BASE_ADDR + 8'd1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_GNT = 3'd1,
        WR_LO    = 3'd2,
        WR_HI    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] hold_reg, hold_next;
    logic        winner_reg, winner_next;
    logic        last_reg, last_next;
    logic        raise_reg, raise_next;
    logic        pick;
    logic        drive;

    // On a tie the requester not served last wins; otherwise the lone requester.
    always_comb begin
        pick = 1'b0;
        if (ctl.req == 2'b11) begin
            pick = ~last_reg;
        end else begin
            pick = ~ctl.req[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            hold_reg   <= 16'h0000;
            winner_reg <= 1'b0;
            last_reg   <= 1'b1;
            raise_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hold_reg   <= hold_next;
            winner_reg <= winner_next;
            last_reg   <= last_next;
            raise_reg  <= raise_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        hold_next   = hold_reg;
        winner_next = winner_reg;
        last_next   = last_reg;
        raise_next  = raise_reg;

        case (state_reg)
            IDLE: begin
                if (ctl.req != 2'b00) begin
                    winner_next = pick;
                    hold_next   = pick ? ctl.val1 : ctl.val0;
                    state_next  = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (ctl.bus_gnt) begin
                    state_next = WR_LO;
                end
            end
            // Losing the grant mid-transfer restarts the whole two-byte write.
            WR_LO: begin
                state_next = ctl.bus_gnt ? WR_HI : WAIT_GNT;
            end
            WR_HI: begin
                state_next = ctl.bus_gnt ? DONE : WAIT_GNT;
            end
            DONE: begin
                last_next  = winner_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Setting wins over a coincident clear so a completion is never lost.
        if (state_reg == DONE) begin
            raise_next = 1'b1;
        end else if (ctl.bus_interrupt_ack) begin
            raise_next = 1'b0;
        end
    end

    assign drive = (state_reg == WR_LO) || (state_reg == WR_HI);

    assign bus_addr = drive ? ((state_reg == WR_HI) ? HI_ADDR : BASE_ADDR) : 8'hzz;
    assign bus_data = drive ? ((state_reg == WR_HI) ? hold_reg[15:8] : hold_reg[7:0]) : 8'hzz;
    assign bus_we   = drive ? 1'b1 : 1'bz;

    assign ctl.bus_req = (state_reg == WAIT_GNT) || drive;
    assign ctl.bus_interrupt_raise = raise_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ctl.ack[gi] = (state_reg == DONE) && (winner_reg == gi[0]);
        end
    endgenerate
endmodule
